con_bus_arbiter: RTL and testbench

CON_BUS_ARBITER -- requirements
Module: con_bus_arbiter

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/con_bus_arbiter.sv | 94 +++++++++
 tb/tb_con_bus_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared arbiter state encoding, default burst lengths and the register macro
//   CTRL_REG(clk, rst_n, q, d, rv): flop q <= d on rising clk, async active-low reset to rv.
`ifndef CTRL_REG
`define CTRL_REG(clk_s, rst_s, q, d, rv) \
    always_ff @(posedge clk_s or negedge rst_s) \
        if (!rst_s) q <= (rv); \
        else q <= (d);
`endif

package ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_K = 2'd1,
        ST_GRANT_I = 2'd2
    } arb_state_t;
    localparam int K_BURST_LEN_DEF = 12;
    localparam int I_BURST_LEN_DEF = 4;
endpackage

// File: rtl/con_bus_arbiter.sv
// con_bus_arbiter: round-robin burst arbiter steering the con bus to the kernel or input loader
//   clk, arst_n_in       : clock, asynchronous active-low reset
//   req_k, req_i         : level burst requests
//   con_valid, con_data  : external word stream; con_ready accepts it
//   gnt_k, gnt_i         : registered one-hot-or-zero burst grant
//   k_we, i_we, wr_data  : write strobes and forwarded data to the granted loader
//   beat_idx             : beat index within the current burst
//   done_k, done_i       : pulse on the last beat of a burst
//   busy                 : any grant active
//   stat_k_bursts, stat_i_bursts : completed-burst counters, only with CON_BUS_ARB_STATS_EN
module con_bus_arbiter
    import ctrl_pkg::*;
#(
    parameter int K_BURST_LEN = K_BURST_LEN_DEF,
    parameter int I_BURST_LEN = I_BURST_LEN_DEF,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  req_k,
    input  logic                  req_i,
    input  logic                  con_valid,
    input  logic [DATA_WIDTH-1:0] con_data,
    output logic                  con_ready,
    output logic                  gnt_k,
    output logic                  gnt_i,
    output logic                  k_we,
    output logic                  i_we,
    output logic [3:0]            beat_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done_k,
    output logic                  done_i,
    output logic                  busy
`ifdef CON_BUS_ARB_STATS_EN
    ,
    output logic [15:0]           stat_k_bursts,
    output logic [15:0]           stat_i_bursts
`endif
);
    localparam logic [3:0] K_LAST = 4'(K_BURST_LEN - 1);
    localparam logic [3:0] I_LAST = 4'(I_BURST_LEN - 1);

    arb_state_t r_state, w_state_nxt;
    logic [3:0] r_beat, w_beat_nxt;
    logic       r_last_i, w_last_i_nxt;
    logic       w_beat, w_last_beat;
    logic [3:0] w_last_idx;

    assign busy        = (r_state != ST_IDLE);
    assign con_ready   = busy;
    assign gnt_k       = (r_state == ST_GRANT_K);
    assign gnt_i       = (r_state == ST_GRANT_I);
    assign w_beat      = con_valid && con_ready;
    assign w_last_idx  = gnt_k ? K_LAST : I_LAST;
    assign w_last_beat = w_beat && (r_beat == w_last_idx);
    assign k_we        = gnt_k && w_beat;
    assign i_we        = gnt_i && w_beat;
    assign done_k      = gnt_k && w_last_beat;
    assign done_i      = gnt_i && w_last_beat;
    assign beat_idx    = r_beat;
    // Data is zero outside a grant so every output stays quiet while idle or in reset.
    assign wr_data     = busy ? con_data : '0;

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_last_i_nxt = r_last_i;
        if (r_state == ST_IDLE) begin
            // On a tie K wins only when I was granted last.
            if (req_k && (!req_i || r_last_i))
                w_state_nxt = ST_GRANT_K;
            else if (req_i)
                w_state_nxt = ST_GRANT_I;
        end else if (w_last_beat) begin
            w_state_nxt  = ST_IDLE;
            w_beat_nxt   = 4'd0;
            w_last_i_nxt = (r_state == ST_GRANT_I);
        end else if (w_beat) begin
            w_beat_nxt = r_beat + 4'd1;
        end
    end

    `CTRL_REG(clk, arst_n_in, r_state, w_state_nxt, ST_IDLE)
    `CTRL_REG(clk, arst_n_in, r_beat, w_beat_nxt, 4'd0)
    `CTRL_REG(clk, arst_n_in, r_last_i, w_last_i_nxt, 1'b1)

`ifdef CON_BUS_ARB_STATS_EN
    logic [15:0] r_stat_k, r_stat_i;
    `CTRL_REG(clk, arst_n_in, r_stat_k, r_stat_k + 16'(done_k), 16'd0)
    `CTRL_REG(clk, arst_n_in, r_stat_i, r_stat_i + 16'(done_i), 16'd0)
    assign stat_k_bursts = r_stat_k;
    assign stat_i_bursts = r_stat_i;
`endif
endmodule

// File: tb/tb_con_bus_arbiter.sv
// tb_con_bus_arbiter: scoreboard bench for con_bus_arbiter (default 12/4-beat bursts, 32-bit data)
module tb_con_bus_arbiter;
    logic        clk = 1'b0;
    logic        arst_n_in = 1'b0;
    logic        req_k = 1'b0, req_i = 1'b0, con_valid = 1'b0;
    logic [31:0] con_data = '0;
    logic        con_ready, gnt_k, gnt_i, k_we, i_we, done_k, done_i, busy;
    logic [3:0]  beat_idx;
    logic [31:0] wr_data;
`ifdef CON_BUS_ARB_STATS_EN
    logic [15:0] stat_k_bursts, stat_i_bursts;
`endif

    con_bus_arbiter dut (
        .clk(clk), .arst_n_in(arst_n_in), .req_k(req_k), .req_i(req_i),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
        .gnt_k(gnt_k), .gnt_i(gnt_i), .k_we(k_we), .i_we(i_we),
        .beat_idx(beat_idx), .wr_data(wr_data), .done_k(done_k), .done_i(done_i),
        .busy(busy)
`ifdef CON_BUS_ARB_STATS_EN
        , .stat_k_bursts(stat_k_bursts), .stat_i_bursts(stat_i_bursts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] ctl;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   done_log[$];
    int   n_chk = 0, n_pass = 0, n_kwe = 0, n_iwe = 0;
    // Reference model: 0 idle, 1 kernel burst, 2 input burst.
    int   m_st = 0, m_idx = 0;
    bit   m_last_i = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [11:0] obs();
        return {busy, con_ready, gnt_k, gnt_i, k_we, i_we, done_k, done_i, beat_idx};
    endfunction

    task automatic m_reset();
        m_st = 0;
        m_idx = 0;
        m_last_i = 1'b1;
    endtask

    // One cycle: drive at posedge+1, predict, compare at negedge, advance the model.
    task automatic step(input logic rk, input logic ri, input logic v);
        exp_t e, got_e;
        bit   bsy, gk, gi, bt, lastb;
        int   len;
        req_k = rk;
        req_i = ri;
        con_valid = v;
        con_data = $urandom;
        bsy = (m_st != 0) && arst_n_in;
        gk = bsy && m_st == 1;
        gi = bsy && m_st == 2;
        bt = v && bsy;
        len = gk ? 12 : 4;
        lastb = bt && (m_idx == len - 1);
        e.ctl = {bsy, bsy, gk, gi, gk && bt, gi && bt, gk && lastb, gi && lastb, 4'(m_idx)};
        e.data = bsy ? con_data : 32'd0;
        sb.push_back(e);
        @(negedge clk);
        got_e = sb.pop_front();
        check("ctl", 32'(obs()), 32'(got_e.ctl));
        check("wr_data", wr_data, got_e.data);
        if (done_k) done_log.push_back(1);
        if (done_i) done_log.push_back(2);
        if (k_we) n_kwe++;
        if (i_we) n_iwe++;
        if (!arst_n_in) m_reset();
        else if (m_st == 0) begin
            if (rk && ri) m_st = m_last_i ? 1 : 2;
            else if (rk) m_st = 1;
            else if (ri) m_st = 2;
        end else if (bt) begin
            if (lastb) begin
                m_last_i = (m_st == 2);
                m_st = 0;
                m_idx = 0;
            end else m_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n_in = 1'b0;
        req_k = 1'b0;
        req_i = 1'b0;
        con_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n_in = 1'b1;
        m_reset();
    endtask

    initial begin
        // Reset state, even with requests asserted.
        repeat (2) @(posedge clk);
        #1;
        step(1, 1, 1);
        arst_n_in = 1'b1;

        // Single K burst with valid held high.
        done_log = {};
        n_kwe = 0;
        for (int i = 0; i < 13; i++) step(i < 12, 0, 1);
        step(0, 0, 0);
        check("k_we_count", n_kwe, 12);
        check("k_done_count", done_log.size(), 1);
        check("k_done_who", done_log[0], 1);

        // Tie from reset: K, idle, I, idle, K.
        do_reset();
        done_log = {};
        for (int i = 0; i < 20; i++) step(1, 1, 1);
        check("rr_done_count", done_log.size(), 2);
        check("rr_first", done_log[0], 1);
        check("rr_second", done_log[1], 2);
        check("rr_third_gnt", {30'd0, gnt_k, gnt_i}, 32'b10);
        for (int i = 0; i < 11; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Valid toggling in an I burst.
        done_log = {};
        n_iwe = 0;
        step(0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, (i % 2) == 0);
        check("tog_iwe_count", n_iwe, 4);
        check("tog_done", done_log.size(), 1);
        check("tog_idle", busy, 0);

        // req_i dropped after beat 1.
        done_log = {};
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        check("drop_done_count", done_log.size(), 1);
        check("drop_done_who", done_log[0], 2);

        // Async reset at beat 5 of a K burst.
        done_log = {};
        for (int i = 0; i < 6; i++) step(1, 0, 1);
        check("pre_rst_idx", beat_idx, 5);
        req_k = 1'b1;
        con_valid = 1'b1;
        con_data = 32'hA5A5_5A5A;
        #3;
        arst_n_in = 1'b0;
        #1;
        check("rst_ctl", 32'(obs()), 0);
        check("rst_data", wr_data, 0);
        @(posedge clk);
        #1;
        check("rst_hold_ctl", 32'(obs()), 0);
        arst_n_in = 1'b1;
        m_reset();
        check("rst_no_done", done_log.size(), 0);
        step(1, 1, 0);
        step(1, 1, 0);
        check("rst_tie_k", {30'd0, gnt_k, gnt_i}, 32'b10);

        // Three K and two I bursts.
        do_reset();
        done_log = {};
        for (int i = 0; i < 49; i++) step(1, 1, 1);
        step(0, 0, 0);
        check("stat_done_count", done_log.size(), 5);
`ifdef CON_BUS_ARB_STATS_EN
        check("stat_k", stat_k_bursts, 3);
        check("stat_i", stat_i_bursts, 2);
`endif
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
